// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the programmable sequence generator.
// The default pattern matches the legacy fixed 8-entry generator.
package seq_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_LOOP    = 1'b1;

    localparam int DEFAULT_LEN = 8;

    // Entry 0 lives in the least significant byte.
    localparam logic [8*DEFAULT_LEN-1:0] DEFAULT_PATTERN = {
        8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
    };

    function automatic logic [7:0] default_entry(input int idx);
        if (idx >= 0 && idx < DEFAULT_LEN) begin
            return DEFAULT_PATTERN[8*idx +: 8];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/seq_table_ram.sv
// DEPTH x DATA_W pattern register file: one write port, one combinational read.
// Every entry reverts to the package default pattern on reset.
module seq_table_ram
    import seq_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    // Writes to addresses outside the table never match any entry.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem[i] <= DATA_W'(default_entry(i));
            end else if (wr_en && wr_addr == AW'(i)) begin
                mem[i] <= wr_data;
            end
        end
    end

    assign rd_data = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;

endmodule

// File: rtl/seq_pattern_gen.sv
// Programmable pattern sequencer streaming a runtime-writable table over valid/ready,
// in loop or one-shot mode, with stop and write-first bypass into the output register.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [LW-1:0]     len,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    state_t          state, state_nxt;
    logic [AW-1:0]   idx, idx_nxt;
    logic            mode_q, mode_nxt;
    logic [LW-1:0]   len_q, len_nxt;
    logic            stop_pend, stop_pend_nxt;
    logic            out_valid_nxt;
    logic            done_nxt;

    logic            load_en;
    logic [AW-1:0]   load_idx;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] load_data;

    logic            transfer;
    logic            last;
    logic            stop_eff;
    logic [LW-1:0]   len_clamped;

    assign transfer    = out_valid && out_ready;
    assign last        = (LW'(idx) == len_q - LW'(1));
    assign stop_eff    = stop_pend || stop;
    assign len_clamped = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
    assign busy        = (state == RUN);

    seq_table_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_table (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (load_idx),
        .rd_data (rd_data)
    );

    // Write-first: a write landing on the entry being loaded goes straight to the output.
    assign load_data = (wr_en && wr_addr == load_idx) ? wr_data : rd_data;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        mode_nxt      = mode_q;
        len_nxt       = len_q;
        stop_pend_nxt = stop_pend;
        out_valid_nxt = out_valid;
        done_nxt      = 1'b0;
        load_en       = 1'b0;
        load_idx      = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    mode_nxt      = mode;
                    len_nxt       = len_clamped;
                    idx_nxt       = '0;
                    load_en       = 1'b1;
                    out_valid_nxt = 1'b1;
                    stop_pend_nxt = 1'b0;
                    state_nxt     = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    stop_pend_nxt = 1'b1;
                end
                if (transfer) begin
                    if (stop_eff || (last && mode_q == MODE_ONESHOT)) begin
                        state_nxt     = IDLE;
                        out_valid_nxt = 1'b0;
                        stop_pend_nxt = 1'b0;
                        done_nxt      = last && (mode_q == MODE_ONESHOT);
                    end else if (last) begin
                        idx_nxt  = '0;
                        load_en  = 1'b1;
                    end else begin
                        idx_nxt  = idx + AW'(1);
                        load_en  = 1'b1;
                        load_idx = idx + AW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            mode_q    <= MODE_ONESHOT;
            len_q     <= DEPTH_L;
            stop_pend <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            mode_q    <= mode_nxt;
            len_q     <= len_nxt;
            stop_pend <= stop_pend_nxt;
            out_valid <= out_valid_nxt;
            done      <= done_nxt;
            if (load_en) begin
                out_data <= load_data;
            end
        end
    end

endmodule

// File: doc/seq_pattern_gen.md
# seq_pattern_gen

Parametrised programmable sequence generator: a DEPTH-entry, DATA_W-bit pattern table, runtime-writable, streamed out in order over a valid/ready handshake in loop or one-shot mode. It supersedes the fixed 8-entry generator in the stimulus/pattern path. The table resets to the standard 8-value pattern, so default behaviour is backward compatible. Downstream consumers can stall it and the sequence cannot advance without acceptance.

## Interface
- DATA_W, 8, width of each pattern entry (>=1)
- DEPTH, 8, number of table entries (>=2); AW = $clog2(DEPTH), LW = $clog2(DEPTH+1)

- clk  in  1  clock; all logic rising-edge
- reset_n  in  1  reset, asynchronous and active-low
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write address; addresses >= DEPTH ignored
- wr_data  in  DATA_W  table write data
- start  in  1  begin a run (honoured in IDLE only)
- stop  in  1  end a loop run at the next accepted beat (honoured in RUN only)
- mode  in  1  1 = loop, 0 = one-shot; latched at start
- len  in  LW  active entries per pass; latched at start; 0 or >DEPTH → DEPTH
- out_data  out  DATA_W  current pattern entry (registered)
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts beat
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a one-shot pass completes

## Operation
- Reset: table = AF, BC, E2, 78, FF, E2, 0B, 8D (entries 0..7, truncated to DATA_W LSBs); entries >=8 = 0; DEPTH<8 keeps the first DEPTH values. State IDLE, idx=0, out_data=0, out_valid=0, busy=0, done=0.
- States: IDLE, RUN.
- IDLE, start=1: latch mode_q and len_q (clamped), idx←0, out_data←table[0], out_valid←1, go to RUN. stop is ignored in IDLE.
- RUN, beat transfer (out_valid && out_ready):
  - idx < len_q−1: idx←idx+1; out_data←table[idx+1].
  - idx = len_q−1, loop mode, no stop pending: idx←0; out_data←table[0] (wrap).
  - idx = len_q−1, one-shot mode: go to IDLE; out_valid←0; done←1 for one cycle.
- stop in RUN sets stop_pend. At the next transfer (including one in the same cycle as stop), go to IDLE and drop out_valid; done stays 0. In one-shot mode, if that transfer is the final beat, done still pulses.
- RUN, no transfer: out_data and out_valid hold. A beat is never dropped or changed while pending.
- start in RUN is ignored.
- Writes may occur in any state.
  - A write to the entry currently displayed does not alter out_data.
  - A write to the entry being loaded in the same cycle is bypassed (write-first); out_data takes wr_data.
- len_q=1 in loop mode repeats table[0] on every beat.

## Timing
- start at edge N → out_valid=1, out_data=table[0] after edge N+1 (1-cycle latency).
- With out_ready held high: one beat per cycle, no bubbles, including across the wrap.
- The final one-shot transfer at edge M drops out_valid and raises done after M; done clears after M+1. busy falls with out_valid.
- out_valid falls only after a transfer. The consumer may hold out_ready high indefinitely.
- Reset asserted mid-run: all outputs return to reset values asynchronously, and table contents revert to defaults.

## Structure
- Package seq_gen_pkg:
  - state enum (IDLE, RUN)
  - MODE_ONESHOT=1'b0, MODE_LOOP=1'b1
  - the 8-entry default pattern constant
- Sub-module seq_table_ram: DEPTH×DATA_W register file with reset defaults from the package, one write port and one combinational read port. Bypass logic lives in seq_pattern_gen.

## Test plan
- Reset defaults, loop mode: reset, start with len=0, ready=1 → out_data AF,BC,E2,78,FF,E2,0B,8D,AF,… one per cycle; busy=1.
- One-shot, len=3: output AF,BC,E2, then out_valid=0 with a single done pulse; a second start replays from AF.
- Backpressure: toggle out_ready pseudo-randomly → the accepted stream is exactly the sequence, and out_data is stable while out_valid && !out_ready.
- Table write + bypass: write 5A to entry 1 in the cycle AF is accepted → next beat is 5A. Write to entry 0 while AF is displayed → AF unchanged; 3C appears on the next wrap.
- stop: in loop mode, stop asserted while BC is pending with ready=0, then ready=1 → BC accepted, then IDLE; no done; no further beats.
- Async reset mid-run after writes: out_valid=0 and out_data=0 immediately; the next start outputs AF, proving the table was restored.
